axis_stream_fifo: RTL and testbench

//  - AXI4-Stream FIFO that sits directly downstream of the test DMA stream source.
//  - Absorbs 32-bit beats, including the 64-beat bursts terminated by tlast, and re-presents them
//    on a master stream port toward the DMA/host side.
//  - Decouples source bursts from sink back-pressure.
//  - Exposes fill level and a packet counter for GPIO/LED debug.

---
 rtl/axis_stream_fifo_if.sv | 14 +
 rtl/axis_stream_fifo.sv | 87 ++++++++
 tb/tb_axis_stream_fifo.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/axis_stream_fifo_if.sv
// AXI4-Stream beat bundle shared by both sides of axis_stream_fifo.
// The master drives data/valid and the slave drives ready.
interface axis_stream_fifo_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_stream_fifo.sv
// First-word-fall-through AXI4-Stream FIFO with fill level and packet counter.
// Define AXIS_FIFO_PKT_MODE_EN for store-and-forward; the default build is cut-through.
module axis_stream_fifo #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  axis_stream_fifo_if.slave     s,
  axis_stream_fifo_if.master    m,
  output logic [DEPTH_LOG2:0]   level,
  output logic [15:0]           pkt_count,
  output logic                  full,
  output logic                  empty
);
  localparam int KEEP_W  = DATA_W / 8;
  localparam int ENTRY_W = DATA_W + KEEP_W + 1;
  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [ENTRY_W-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  wr_en;
  logic                  rd_en;

  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);

  // Ready is held low during reset so no beat is taken while state is being cleared.
  assign s.tready = !full && !reset;
  assign wr_en    = s.tvalid && s.tready;
  assign rd_en    = m.tvalid && m.tready;

  assign {m.tlast, m.tkeep, m.tdata} = mem[rd_ptr];

`ifdef AXIS_FIFO_PKT_MODE_EN
  logic [DEPTH_LOG2:0] pkt_stored;

  always_ff @(posedge clock) begin
    if (reset) begin
      pkt_stored <= '0;
    end else begin
      case ({wr_en && s.tlast, rd_en && m.tlast})
        2'b10:   pkt_stored <= pkt_stored + 1'b1;
        2'b01:   pkt_stored <= pkt_stored - 1'b1;
        default: pkt_stored <= pkt_stored;
      endcase
    end
  end

  // Full override lets packets longer than the storage drain as cut-through.
  assign m.tvalid = !empty && ((pkt_stored != '0) || full);
`else
  assign m.tvalid = !empty;
`endif

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= {s.tlast, s.tkeep, s.tdata};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      pkt_count <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (wr_en && s.tlast) begin
        pkt_count <= pkt_count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_axis_stream_fifo.sv
// Directed bench for axis_stream_fifo: reset, fill/drain, streaming, random traffic,
// mid-packet reset and (when AXIS_FIFO_PKT_MODE_EN is defined) store-and-forward gating.
module tb_axis_stream_fifo;
  localparam int DATA_W     = 32;
  localparam int DEPTH_LOG2 = 6;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [DEPTH_LOG2:0] level;
  logic [15:0]         pkt_count;
  logic                full;
  logic                empty;

  axis_stream_fifo_if #(.DATA_W(DATA_W)) s_if ();
  axis_stream_fifo_if #(.DATA_W(DATA_W)) m_if ();

  axis_stream_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .s         (s_if.slave),
    .m         (m_if.master),
    .level     (level),
    .pkt_count (pkt_count),
    .full      (full),
    .empty     (empty)
  );

  always #5 clock = ~clock;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [36:0] sb [$];
  bit          wr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic [31:0] data, input logic last);
    s_if.tvalid = valid;
    s_if.tdata  = data;
    s_if.tkeep  = 4'hF;
    s_if.tlast  = last;
  endtask

  // Inputs are already driven; sample handshakes, advance one edge, check model state.
  task automatic tick(output bit wrote);
    logic        hold;
    logic [36:0] held;
    #1;
    wrote = s_if.tvalid && s_if.tready;
    hold  = !reset && m_if.tvalid && !m_if.tready;
    held  = {m_if.tlast, m_if.tkeep, m_if.tdata};
    if (reset) begin
      sb.delete();
    end else begin
      if (m_if.tvalid && m_if.tready) begin
        if (sb.size() == 0) check("rd_underflow", 64'd1, 64'd0);
        else                check("rd_beat", 64'(held), 64'(sb.pop_front()));
      end
      if (wrote) sb.push_back({s_if.tlast, s_if.tkeep, s_if.tdata});
    end
    @(posedge clock);
    #1;
    check("level", 64'(level), 64'(sb.size()));
    check("full",  64'(full),  64'(sb.size() == DEPTH));
    check("empty", 64'(empty), 64'(sb.size() == 0));
    if (hold) begin
      check("hold_valid", 64'(m_if.tvalid), 64'd1);
      check("hold_data",  64'({m_if.tlast, m_if.tkeep, m_if.tdata}), 64'(held));
    end
  endtask

  initial begin
    int n;
    int cyc;
    drive(1'b0, '0, 1'b0);
    m_if.tready = 1'b0;

    // Reset state
    reset = 1'b1;
    repeat (3) tick(wr);
    reset = 1'b0;
    #1;
    check("rst_s_tready", 64'(s_if.tready), 64'd1);
    check("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    check("rst_level",    64'(level),       64'd0);
    check("rst_empty",    64'(empty),       64'd1);
    check("rst_pkt",      64'(pkt_count),   64'd0);

    // Fill with one 64-beat burst, then drain
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 32'(i), i == 63);
      tick(wr);
    end
    drive(1'b0, '0, 1'b0);
    check("fill_level",    64'(level),       64'd64);
    check("fill_full",     64'(full),        64'd1);
    check("fill_s_tready", 64'(s_if.tready), 64'd0);
    check("fill_pkt",      64'(pkt_count),   64'd1);
    check("fill_m_tvalid", 64'(m_if.tvalid), 64'd1);
    check("fill_head",     64'(m_if.tdata),  64'd0);
    m_if.tready = 1'b1;
    for (int i = 0; i < 64; i++) tick(wr);
    check("drain_empty", 64'(empty), 64'd1);

    // Continuous streaming, one-cycle pass-through, three pointer wraps
    for (int i = 0; i < 200; i++) begin
      drive(1'b1, 32'(1000 + i), 1'b1);
      tick(wr);
      if (i == 0 || i == 63 || i == 64 || i == 199) begin
        check("stream_level", 64'(level),      64'd1);
        check("stream_data",  64'(m_if.tdata), 64'(1000 + i));
      end
    end
    drive(1'b0, '0, 1'b0);
    tick(wr);
    check("stream_pkt", 64'(pkt_count), 64'd201);

    // Random valid/ready, 1000 beats in 10-beat packets
    n = 0;
    cyc = 0;
    while ((n < 1000 || sb.size() != 0) && cyc < 20000) begin
      s_if.tvalid = (n < 1000) && ($urandom_range(1) == 1);
      s_if.tdata  = $urandom;
      s_if.tkeep  = 4'($urandom_range(15));
      s_if.tlast  = (n % 10 == 9);
      m_if.tready = (n >= 1000) || ($urandom_range(1) == 1);
      tick(wr);
      if (wr) n++;
      cyc++;
    end
    drive(1'b0, '0, 1'b0);
    check("rand_timeout", 64'(cyc < 20000), 64'd1);
    check("rand_pkt",     64'(pkt_count),   64'd301);

    // Reset in the middle of a burst
    m_if.tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'(500 + i), 1'b0);
      tick(wr);
    end
    drive(1'b0, '0, 1'b0);
    reset = 1'b1;
    tick(wr);
    check("mid_rst_level",    64'(level),       64'd0);
    check("mid_rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hA0 + 32'(i), i == 3);
      tick(wr);
    end
    drive(1'b0, '0, 1'b0);
    check("post_rst_head", 64'(m_if.tdata), 64'hA0);
    check("post_rst_pkt",  64'(pkt_count),  64'd1);
    m_if.tready = 1'b1;
    for (int i = 0; i < 4; i++) tick(wr);
    check("post_rst_empty", 64'(empty), 64'd1);

`ifdef AXIS_FIFO_PKT_MODE_EN
    // Store-and-forward: nothing presented until a whole packet is stored
    m_if.tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'(700 + i), 1'b0);
      tick(wr);
    end
    check("pkt_wait_valid", 64'(m_if.tvalid), 64'd0);
    drive(1'b1, 32'd705, 1'b1);
    tick(wr);
    drive(1'b0, '0, 1'b0);
    check("pkt_done_valid", 64'(m_if.tvalid), 64'd1);
    m_if.tready = 1'b1;
    for (int i = 0; i < 6; i++) tick(wr);
    check("pkt_drain_empty", 64'(empty), 64'd1);

    // Oversized packet: full override starts output at level 64
    m_if.tready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 32'(900 + i), 1'b0);
      tick(wr);
      if (i == 62) check("long_wait_valid", 64'(m_if.tvalid), 64'd0);
    end
    check("long_full_valid", 64'(m_if.tvalid), 64'd1);
    check("long_full_level", 64'(level),       64'd64);
    m_if.tready = 1'b1;
    n = 64;
    cyc = 0;
    while ((n < 70 || sb.size() != 0) && cyc < 1000) begin
      drive(n < 70, 32'(900 + n), n == 69);
      tick(wr);
      if (wr) n++;
      cyc++;
    end
    drive(1'b0, '0, 1'b0);
    check("long_timeout", 64'(cyc < 1000), 64'd1);
    check("long_empty",   64'(empty),      64'd1);
`else
    // Cut-through: a beat is presented without waiting for tlast
    m_if.tready = 1'b0;
    drive(1'b1, 32'd777, 1'b0);
    tick(wr);
    drive(1'b0, '0, 1'b0);
    check("ct_valid", 64'(m_if.tvalid), 64'd1);
    check("ct_data",  64'(m_if.tdata),  64'd777);
    m_if.tready = 1'b1;
    tick(wr);
    check("ct_empty", 64'(empty), 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
